// File: rtl/s2p_blk_ctrl.sv
// Serial-to-parallel block assembler: gathers WPB tagged FIFO words into one
// SM4 block, checks sof/key framing, and hands the block off with valid/ready.
module s2p_blk_ctrl #(
    parameter int IO_WIDTH  = 32,
    parameter int BLK_WIDTH = 128
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 fifo_empty,
    input  logic [IO_WIDTH+1:0]  fifo_dout,
    output logic                 fifo_rd_en,
    output logic                 fifo_fake_rd,
    input  logic                 abort,
    output logic                 blk_valid,
    input  logic                 blk_ready,
    output logic [BLK_WIDTH-1:0] blk_data,
    output logic                 blk_is_key,
    output logic [7:0]           err_cnt
);

    localparam int WPB = BLK_WIDTH / IO_WIDTH;
    localparam int CW  = $clog2(WPB + 1);
    localparam logic [CW-1:0] WPB_C = CW'(WPB);

    typedef enum logic [1:0] {IDLE, FILL, OUT, FLUSH} state_t;

    state_t              state;
    logic [CW-1:0]       req_cnt;
    logic [CW-1:0]       rcv_cnt;
    logic [CW-1:0]       rcv_next;
    logic [CW-1:0]       slot;
    logic                rvalid_q;
    logic                capture;
    logic                frame_err;
    logic                slot_we;
    logic                word_key;
    logic                word_sof;
    logic [IO_WIDTH-1:0] word_data;

    assign word_key  = fifo_dout[IO_WIDTH+1];
    assign word_sof  = fifo_dout[IO_WIDTH];
    assign word_data = fifo_dout[IO_WIDTH-1:0];

    // The fake read is the only read FLUSH issues; real reads stop once WPB are requested.
    assign fifo_fake_rd = (state == FLUSH);
    assign fifo_rd_en   = fifo_fake_rd ||
                          ((state == FILL) && !fifo_empty && !abort && (req_cnt < WPB_C));
    assign capture      = (state == FILL) && rvalid_q && !abort;

    always_comb begin
        frame_err = 1'b0;
        slot_we   = 1'b0;
        slot      = '0;
        rcv_next  = rcv_cnt;
        if (capture) begin
            if (rcv_cnt == '0) begin
                frame_err = !word_sof;
            end else begin
                frame_err = word_sof || (word_key != blk_is_key);
            end
            if (!frame_err) begin
                slot_we  = 1'b1;
                slot     = rcv_cnt;
                rcv_next = rcv_cnt + CW'(1);
            end else if (word_sof) begin
                slot_we  = 1'b1;
                slot     = '0;
                rcv_next = CW'(1);
            end else begin
                rcv_next = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_cnt    <= '0;
            rcv_cnt    <= '0;
            rvalid_q   <= 1'b0;
            blk_valid  <= 1'b0;
            blk_data   <= '0;
            blk_is_key <= 1'b0;
            err_cnt    <= '0;
        end else begin
            rvalid_q <= fifo_rd_en;
            if (capture && frame_err && (err_cnt != 8'hFF)) begin
                err_cnt <= err_cnt + 8'd1;
            end
            if (slot_we) begin
                for (int i = 0; i < WPB; i++) begin
                    if (slot == CW'(i)) begin
                        blk_data[BLK_WIDTH-1-i*IO_WIDTH -: IO_WIDTH] <= word_data;
                    end
                end
                if (slot == '0) begin
                    blk_is_key <= word_key;
                end
            end
            case (state)
                IDLE: begin
                    req_cnt <= '0;
                    rcv_cnt <= '0;
                    if (abort) begin
                        state <= FLUSH;
                    end else if (!fifo_empty) begin
                        state <= FILL;
                    end
                end
                FILL: begin
                    if (abort) begin
                        req_cnt <= '0;
                        rcv_cnt <= '0;
                        state   <= FLUSH;
                    end else begin
                        // At most one read is ever in flight, so requests = received + this cycle's read.
                        rcv_cnt <= rcv_next;
                        req_cnt <= rcv_next + CW'(fifo_rd_en);
                        if (rcv_next == WPB_C) begin
                            state     <= OUT;
                            blk_valid <= 1'b1;
                        end
                    end
                end
                OUT: begin
                    if (blk_ready) begin
                        blk_valid <= 1'b0;
                        req_cnt   <= '0;
                        rcv_cnt   <= '0;
                        state     <= fifo_empty ? IDLE : FILL;
                    end
                end
                FLUSH: begin
                    req_cnt <= '0;
                    rcv_cnt <= '0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_s2p_blk_ctrl.sv
// Bench for s2p_blk_ctrl: a queue-backed FIFO model with 1-cycle read latency,
// and a list-based framing model that predicts delivered blocks and error count.
module tb_s2p_blk_ctrl;

    localparam int IO_WIDTH  = 32;
    localparam int BLK_WIDTH = 128;
    localparam int WPB       = BLK_WIDTH / IO_WIDTH;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 fifo_empty = 1'b1;
    logic [IO_WIDTH+1:0]  fifo_dout = '0;
    logic                 fifo_rd_en;
    logic                 fifo_fake_rd;
    logic                 abort = 1'b0;
    logic                 blk_valid;
    logic                 blk_ready = 1'b0;
    logic [BLK_WIDTH-1:0] blk_data;
    logic                 blk_is_key;
    logic [7:0]           err_cnt;

    s2p_blk_ctrl #(.IO_WIDTH(IO_WIDTH), .BLK_WIDTH(BLK_WIDTH)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout),
        .fifo_rd_en(fifo_rd_en), .fifo_fake_rd(fifo_fake_rd), .abort(abort),
        .blk_valid(blk_valid), .blk_ready(blk_ready), .blk_data(blk_data),
        .blk_is_key(blk_is_key), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int err_exp = 0;
    int rd_cnt, fake_cnt, both_cnt, valid_seen, cyc;
    logic s_rd, s_fk, s_valid;

    logic [IO_WIDTH+1:0]  fifo_q[$];
    logic [IO_WIDTH+1:0]  sent_q[$];
    logic [IO_WIDTH+1:0]  next_dout = '0;
    logic [BLK_WIDTH:0]   got_q[$];
    logic [BLK_WIDTH:0]   exp_q[$];

    function automatic logic [IO_WIDTH+1:0] mkw(input logic key, input logic sof,
                                                input logic [IO_WIDTH-1:0] d);
        return {key, sof, d};
    endfunction

    // Framing rules applied to a whole word list; fills exp_q, returns error count.
    function automatic int run_model();
        logic [IO_WIDTH+1:0]  cur[$];
        logic [BLK_WIDTH-1:0] b;
        logic [IO_WIDTH+1:0]  w;
        int e = 0;
        exp_q.delete();
        for (int i = 0; i < sent_q.size(); i++) begin
            w = sent_q[i];
            if (cur.size() == 0) begin
                if (w[IO_WIDTH]) cur.push_back(w);
                else e++;
            end else if (w[IO_WIDTH]) begin
                e++;
                cur.delete();
                cur.push_back(w);
            end else if (w[IO_WIDTH+1] != cur[0][IO_WIDTH+1]) begin
                e++;
                cur.delete();
            end else begin
                cur.push_back(w);
            end
            if (cur.size() == WPB) begin
                b = '0;
                for (int j = 0; j < WPB; j++) b = {b[BLK_WIDTH-IO_WIDTH-1:0], cur[j][IO_WIDTH-1:0]};
                exp_q.push_back({cur[0][IO_WIDTH+1], b});
                cur.delete();
            end
        end
        return e;
    endfunction

    // One clock: called at a falling edge, applies FIFO state, samples, returns at next falling edge.
    task automatic cycle();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = next_dout;
        #1;
        s_rd    = fifo_rd_en;
        s_fk    = fifo_fake_rd;
        s_valid = blk_valid;
        checks++;
        if (s_fk && !s_rd) begin
            errors++;
            $display("FAIL fake_without_rd cyc=%0d: fifo_fake_rd=1 fifo_rd_en=0, required rd_en=1", cyc);
        end
        if (s_rd && !s_fk) begin
            checks++;
            if (fifo_q.size() == 0) begin
                errors++;
                $display("FAIL read_empty cyc=%0d: fifo_rd_en=1 with fifo_empty=1, required 0", cyc);
            end else begin
                next_dout = fifo_q.pop_front();
            end
        end
        if (s_fk) next_dout = {2'b11, IO_WIDTH'($urandom())};
        rd_cnt   += int'(s_rd);
        fake_cnt += int'(s_fk);
        if (s_rd && s_fk) both_cnt++;
        if (s_valid) valid_seen++;
        if (s_valid && blk_ready && rst_n) got_q.push_back({blk_is_key, blk_data});
        cyc++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        abort = 1'b0;
        blk_ready = 1'b0;
        fifo_q.delete();
        next_dout = '0;
        repeat (2) cycle();
        rst_n = 1'b1;
        cycle();
        got_q.delete();
        err_exp = 0;
    endtask

    task automatic wait_drain(input string name, input int budget);
        int k = 0;
        while (fifo_q.size() > 0 && k < budget) begin
            cycle();
            k++;
        end
        checks++;
        if (fifo_q.size() > 0) begin
            errors++;
            $display("FAIL %s_drain_timeout: %0d words left, required 0", name, fifo_q.size());
        end
        repeat (8) cycle();
    endtask

    task automatic test_reset();
        fifo_q.push_back(mkw(1'b0, 1'b1, 32'h1));
        rd_cnt = 0;
        repeat (3) cycle();
        checks++; if (rd_cnt !== 0) begin errors++; $display("FAIL reset_rd_en: %0d reads, required 0", rd_cnt); end
        checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL reset_blk_valid: got %b required 0", blk_valid); end
        checks++; if (blk_data !== '0) begin errors++; $display("FAIL reset_blk_data: got %h required 0", blk_data); end
        checks++; if (blk_is_key !== 1'b0) begin errors++; $display("FAIL reset_blk_is_key: got %b required 0", blk_is_key); end
        checks++; if (err_cnt !== 8'd0) begin errors++; $display("FAIL reset_err_cnt: got %0d required 0", err_cnt); end
        checks++; if (fifo_fake_rd !== 1'b0) begin errors++; $display("FAIL reset_fake_rd: got %b required 0", fifo_fake_rd); end
        fifo_q.delete();
        rst_n = 1'b1;
        repeat (2) cycle();
    endtask

    task automatic test_basic();
        logic [15:0] rd_mask = '0;
        int first_valid = -1;
        fifo_q.push_back(mkw(1'b0, 1'b1, 32'h01234567));
        fifo_q.push_back(mkw(1'b0, 1'b0, 32'h89ABCDEF));
        fifo_q.push_back(mkw(1'b0, 1'b0, 32'hFEDCBA98));
        fifo_q.push_back(mkw(1'b0, 1'b0, 32'h76543210));
        got_q.delete();
        blk_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            rd_mask[i] = s_rd;
            if (s_valid && first_valid < 0) first_valid = i;
        end
        checks++; if (rd_mask !== 16'h001E) begin errors++; $display("FAIL basic_rd_pattern: got %h required 001e", rd_mask); end
        checks++; if (first_valid != 6) begin errors++; $display("FAIL basic_valid_cycle: got %0d required 6", first_valid); end
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL basic_block_count: got %0d required 1", got_q.size());
        end else if (got_q[0] !== {1'b0, 128'h0123456789ABCDEFFEDCBA9876543210}) begin
            errors++; $display("FAIL basic_block: got %h required 0_0123456789abcdeffedcba9876543210", got_q[0]);
        end
        checks++; if (err_cnt !== 8'(err_exp)) begin errors++; $display("FAIL basic_err_cnt: got %0d required %0d", err_cnt, err_exp); end
    endtask

    task automatic test_stall();
        logic [BLK_WIDTH-1:0] snap;
        int k = 0;
        logic [IO_WIDTH+1:0] w;
        sent_q.delete();
        got_q.delete();
        for (int i = 0; i < 8; i++) begin
            w = mkw(1'b1, (i % WPB) == 0, IO_WIDTH'($urandom()));
            fifo_q.push_back(w);
            sent_q.push_back(w);
        end
        err_exp += run_model();
        blk_ready = 1'b0;
        s_valid = 1'b0;
        while (!s_valid && k < 30) begin cycle(); k++; end
        checks++;
        if (!s_valid) begin errors++; $display("FAIL stall_valid_timeout: blk_valid=0 after %0d cycles, required 1", k); end
        snap = blk_data;
        rd_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            cycle();
            checks++;
            if (!s_valid || blk_data !== snap) begin
                errors++;
                $display("FAIL stall_hold cyc=%0d: valid=%b data=%h, required valid=1 data=%h", i, s_valid, blk_data, snap);
            end
        end
        checks++; if (rd_cnt != 0) begin errors++; $display("FAIL stall_no_read: %0d reads, required 0", rd_cnt); end
        blk_ready = 1'b1;
        k = 0;
        while (got_q.size() < 2 && k < 40) begin cycle(); k++; end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL stall_block_count: got %0d required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL stall_block%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
        checks++; if (got_q.size() > 1 && got_q[1][BLK_WIDTH] !== 1'b1) begin errors++; $display("FAIL stall_is_key: got 0 required 1"); end
    endtask

    task automatic test_resync();
        logic [IO_WIDTH+1:0] w;
        logic [5:0] sofs = 6'b101000;
        int e;
        sent_q.delete();
        got_q.delete();
        for (int i = 0; i < 6; i++) begin
            w = mkw(1'b0, sofs[5-i], IO_WIDTH'($urandom()));
            fifo_q.push_back(w);
            sent_q.push_back(w);
        end
        e = run_model();
        err_exp += e;
        blk_ready = 1'b1;
        wait_drain("resync", 40);
        checks++; if (e != 1) begin errors++; $display("FAIL resync_model_err: got %0d required 1", e); end
        checks++; if (err_cnt !== 8'(err_exp)) begin errors++; $display("FAIL resync_err_cnt: got %0d required %0d", err_cnt, err_exp); end
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL resync_block_count: got %0d required 1", got_q.size());
        end else if (got_q[0] !== {1'b0, sent_q[2][31:0], sent_q[3][31:0], sent_q[4][31:0], sent_q[5][31:0]}) begin
            errors++; $display("FAIL resync_block: got %h required words 3-6", got_q[0]);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        valid_seen = 0;
        for (int i = 0; i < 256; i++) fifo_q.push_back(mkw(1'($urandom_range(0, 1)), 1'b0, IO_WIDTH'($urandom())));
        wait_drain("saturate", 400);
        checks++; if (err_cnt !== 8'd255) begin errors++; $display("FAIL saturate_err_cnt: got %0d required 255", err_cnt); end
        checks++; if (valid_seen != 0) begin errors++; $display("FAIL saturate_no_valid: blk_valid high %0d cycles, required 0", valid_seen); end
        do_reset();
    endtask

    task automatic test_abort();
        logic [IO_WIDTH+1:0] w;
        int e;
        got_q.delete();
        blk_ready = 1'b1;
        fifo_q.push_back(mkw(1'b0, 1'b1, IO_WIDTH'($urandom())));
        fifo_q.push_back(mkw(1'b0, 1'b0, IO_WIDTH'($urandom())));
        repeat (8) cycle();
        both_cnt = 0;
        fake_cnt = 0;
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        repeat (5) cycle();
        checks++; if (both_cnt != 1) begin errors++; $display("FAIL abort_flush_cycles: got %0d required 1", both_cnt); end
        checks++; if (fake_cnt != 1) begin errors++; $display("FAIL abort_fake_cycles: got %0d required 1", fake_cnt); end
        sent_q.delete();
        for (int i = 0; i < WPB; i++) begin
            w = mkw(1'b1, i == 0, IO_WIDTH'($urandom()));
            fifo_q.push_back(w);
            sent_q.push_back(w);
        end
        e = run_model();
        err_exp += e;
        wait_drain("abort", 40);
        checks++; if (err_cnt !== 8'(err_exp)) begin errors++; $display("FAIL abort_err_cnt: got %0d required %0d", err_cnt, err_exp); end
        checks++;
        if (got_q.size() != 1) begin
            errors++; $display("FAIL abort_block_count: got %0d required 1", got_q.size());
        end else if (got_q[0] !== exp_q[0]) begin
            errors++; $display("FAIL abort_block: got %h required %h", got_q[0], exp_q[0]);
        end
    endtask

    task automatic test_abort_inflight();
        got_q.delete();
        blk_ready = 1'b1;
        for (int i = 0; i < WPB; i++) fifo_q.push_back(mkw(1'b0, i == 0, IO_WIDTH'($urandom())));
        repeat (3) cycle();
        abort = 1'b1;
        cycle();
        abort = 1'b0;
        sent_q = fifo_q;
        err_exp += run_model();
        wait_drain("inflight", 40);
        checks++; if (err_cnt !== 8'(err_exp)) begin errors++; $display("FAIL inflight_err_cnt: got %0d required %0d", err_cnt, err_exp); end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL inflight_blocks: got %0d required 0", got_q.size()); end
    endtask

    task automatic test_random();
        logic [IO_WIDTH+1:0] pend[$];
        logic key, sof, kk;
        int e;
        do_reset();
        sent_q.delete();
        for (int b = 0; b < 30; b++) begin
            key = 1'($urandom_range(0, 1));
            for (int k = 0; k < WPB; k++) begin
                sof = (k == 0);
                if ($urandom_range(0, 9) == 0) sof = !sof;
                kk = key;
                if ($urandom_range(0, 19) == 0) kk = !kk;
                pend.push_back(mkw(kk, sof, IO_WIDTH'($urandom())));
                sent_q.push_back(pend[$]);
            end
        end
        e = run_model();
        err_exp = (e > 255) ? 255 : e;
        for (int c = 0; c < 3000 && (pend.size() > 0 || fifo_q.size() > 0); c++) begin
            if (pend.size() > 0 && $urandom_range(0, 3) != 0) fifo_q.push_back(pend.pop_front());
            blk_ready = 1'($urandom_range(0, 1));
            cycle();
        end
        checks++;
        if (pend.size() > 0 || fifo_q.size() > 0) begin
            errors++; $display("FAIL random_drain_timeout: %0d words left, required 0", pend.size() + fifo_q.size());
        end
        blk_ready = 1'b1;
        repeat (20) cycle();
        checks++; if (err_cnt !== 8'(err_exp)) begin errors++; $display("FAIL random_err_cnt: got %0d required %0d", err_cnt, err_exp); end
        checks++;
        if (got_q.size() != exp_q.size()) begin
            errors++; $display("FAIL random_block_count: got %0d required %0d", got_q.size(), exp_q.size());
        end else begin
            for (int i = 0; i < got_q.size(); i++) begin
                checks++;
                if (got_q[i] !== exp_q[i]) begin
                    errors++; $display("FAIL random_block%0d: got %h required %h", i, got_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_out();
        int k = 0;
        int n;
        do_reset();
        for (int i = 0; i < WPB; i++) fifo_q.push_back(mkw(1'b1, i == 0, IO_WIDTH'($urandom())));
        s_valid = 1'b0;
        while (!s_valid && k < 20) begin cycle(); k++; end
        checks++; if (!s_valid) begin errors++; $display("FAIL rstout_valid_timeout: blk_valid=0, required 1"); end
        n = got_q.size();
        #2 rst_n = 1'b0;
        #1;
        checks++; if (blk_valid !== 1'b0) begin errors++; $display("FAIL rstout_async_valid: got %b required 0", blk_valid); end
        checks++; if (blk_data !== '0) begin errors++; $display("FAIL rstout_async_data: got %h required 0", blk_data); end
        @(negedge clk);
        blk_ready = 1'b1;
        cycle();
        rst_n = 1'b1;
        repeat (4) cycle();
        checks++; if (got_q.size() != n) begin errors++; $display("FAIL rstout_no_accept: got %0d blocks required %0d", got_q.size(), n); end
        checks++; if (s_valid !== 1'b0) begin errors++; $display("FAIL rstout_after_valid: got %b required 0", s_valid); end
    endtask

    initial begin
        rd_cnt = 0; fake_cnt = 0; both_cnt = 0; valid_seen = 0; cyc = 0;
        s_rd = 1'b0; s_fk = 1'b0; s_valid = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_stall();
        test_resync();
        test_abort();
        test_abort_inflight();
        test_saturate();
        test_random();
        test_reset_mid_out();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

endmodule
